layer_sequencer: RTL

Address and control sequencer for one fully-connected layer of the hardware ANN. On a start command it walks every neuron group and, within each group, every input level, driving `gp`/`level` into the weight, bias and input memories. It aligns accumulator enables with their one-cycle registered read latency and hands each finished group to the activation/writeback stage through a valid/ready handshake. One instance serves each layer: layer 0 uses 4 groups × 8 levels, layer 1 uses 2 groups × 4 levels.

---
 rtl/ann_pkg.sv | 33 +++
 rtl/layer_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer datapath control: sequencer state
// encoding, per-layer geometry and memory read latency.
package ann_pkg;

    // Legacy-compatible raw encodings; the enum below is built on them so
    // older code that compares against plain constants keeps working.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE   = ST_IDLE,
        SEQ_ISSUE  = ST_ISSUE,
        SEQ_DRAIN  = ST_DRAIN,
        SEQ_RESULT = ST_RESULT
    } seq_state_t;

    // Layer geometry: groups of 8 neurons, levels of 8 inputs.
    localparam int L0_GROUPS  = 4;
    localparam int L0_LEVELS  = 8;
    localparam int L1_GROUPS  = 2;
    localparam int L1_LEVELS  = 4;

    // Registered read latency of the weight/bias/input memories.
    localparam int MEM_RD_LAT = 1;

    // Index width that stays legal for a count of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Address/control sequencer for one fully-connected layer.
// Walks every neuron group and, inside each group, every input level,
// aligns accumulator enables with the one-cycle memory read latency and
// hands each finished group downstream over a valid/ready handshake.
//
// Optional build macro: SEQ_ABORT_EN adds an `abort` input that returns the
// sequencer to IDLE from any busy state without a `done` pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; gp/level hold their last values
// ISSUE  | presenting level 0..NUM_LEVELS-1 of the current group
// DRAIN  | last level's memory read still in flight
// RESULT | accumulators final; res_valid held until res_ready
module layer_sequencer
    import ann_pkg::*;
#(
    parameter int NUM_GROUPS = L0_GROUPS,
    parameter int NUM_LEVELS = L0_LEVELS,
    parameter int GP_W       = idx_width(NUM_GROUPS),
    parameter int LV_W       = idx_width(NUM_LEVELS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef SEQ_ABORT_EN
    input  logic            abort,
`endif
    output logic [GP_W-1:0] gp,
    output logic [LV_W-1:0] level,
    output logic            acc_en,
    output logic            acc_bias,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_last,
    output logic            busy,
    output logic            done
);

    localparam logic [GP_W-1:0] GP_LAST = GP_W'(NUM_GROUPS - 1);
    localparam logic [LV_W-1:0] LV_LAST = LV_W'(NUM_LEVELS - 1);

    seq_state_t      state_q, state_d;
    logic [GP_W-1:0] gp_q, gp_d;
    logic [LV_W-1:0] level_q, level_d;
    logic            acc_en_q, acc_en_d;
    logic            acc_bias_q, acc_bias_d;
    logic            done_q, done_d;
    logic            abort_req;
    logic            abort_hit;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only matters while a pass is running; in IDLE it just masks start.
    assign abort_hit = abort_req && (state_q != SEQ_IDLE);

    // Next-state, counter and done-pulse logic for the layer walk.
    always_comb begin
        state_d = state_q;
        gp_d    = gp_q;
        level_d = level_q;
        done_d  = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start && !abort_req) begin
                    state_d = SEQ_ISSUE;
                    gp_d    = '0;
                    level_d = '0;
                end
            end
            SEQ_ISSUE: begin
                // level parks on the last index so RESULT can still see it
                if (level_q == LV_LAST) begin
                    state_d = SEQ_DRAIN;
                end else begin
                    level_d = level_q + 1'b1;
                end
            end
            SEQ_DRAIN: begin
                state_d = SEQ_RESULT;
            end
            SEQ_RESULT: begin
                if (res_ready) begin
                    if (gp_q == GP_LAST) begin
                        state_d = SEQ_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEQ_ISSUE;
                        gp_d    = gp_q + 1'b1;
                        level_d = '0;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // Abort wins over a coincident handshake; indices are left where they were.
        if (abort_hit) begin
            state_d = SEQ_IDLE;
            gp_d    = gp_q;
            level_d = level_q;
            done_d  = 1'b0;
        end
    end

    // Accumulator controls trail the issued address by the memory read latency.
    always_comb begin
        acc_en_d   = (state_q == SEQ_ISSUE) && !abort_hit;
        acc_bias_d = (state_q == SEQ_ISSUE) && (level_q == '0) && !abort_hit;
    end

    // State, counters and the one-stage accumulator-control delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            gp_q       <= '0;
            level_q    <= '0;
            acc_en_q   <= 1'b0;
            acc_bias_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gp_q       <= gp_d;
            level_q    <= level_d;
            acc_en_q   <= acc_en_d;
            acc_bias_q <= acc_bias_d;
            done_q     <= done_d;
        end
    end

    // Outputs are flops or decodes of flops only; no input reaches an output
    // without passing a register.
    assign gp        = gp_q;
    assign level     = level_q;
    assign acc_en    = acc_en_q;
    assign acc_bias  = acc_bias_q;
    assign res_valid = (state_q == SEQ_RESULT);
    assign res_last  = (state_q == SEQ_RESULT) && (gp_q == GP_LAST);
    assign busy      = (state_q != SEQ_IDLE);
    assign done      = done_q;

endmodule
